regfile_write_arbiter: RTL and testbench

//   Shares the register-file write port between two writeback requesters:
//   A = ALU/execute writeback, B = load/memory writeback.

---
 rtl/regfile_write_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B) writeback.
// Optional conflict counter is present only when WB_ARB_STATS_EN is defined.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32
`ifdef WB_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [NREG-1:0]   we,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid
`ifdef WB_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  typedef enum logic [0:0] {StPriA, StPriB} pri_e;

  pri_e              state_q, state_d;
  logic [NREG-1:0]   we_q, we_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Readies are gated by rst_n so nothing is accepted while reset is asserted.
  always_comb begin
    a_ready = rst_n & a_valid & (~b_valid | (state_q == StPriA));
    b_ready = rst_n & b_valid & (~a_valid | (state_q == StPriB));
    xfer    = a_ready | b_ready;
    sel_addr = a_ready ? a_addr : b_addr;
    sel_data = a_ready ? a_data : b_data;
  end

  always_comb begin
    state_d = state_q;
    if (a_ready) begin
      state_d = StPriB;
    end else if (b_ready) begin
      state_d = StPriA;
    end
  end

  // r0 is hardwired zero: the write is accepted and flagged but no enable fires.
  always_comb begin
    we_d = '0;
    for (int i = 1; i < NREG; i++) begin
      we_d[i] = xfer && (sel_addr == ADDR_W'(i));
    end
    wr_data_d  = xfer ? sel_data : wr_data_q;
    wr_valid_d = xfer;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StPriA;
      we_q       <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  assign we       = we_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;

`ifdef WB_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (a_valid && b_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single requesters, round-robin, r0 discard,
// mid-stream reset, and the conflict counter when WB_ARB_STATS_EN is defined.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [31:0] we;
  logic [31:0] wr_data;
  logic        wr_valid;
`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .we           (we),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid)
`ifdef WB_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h00ABCDEF;
    b_valid = 1'b0; b_addr = '0; b_data = '0;

    // 1: reset held two cycles with A requesting
    tick();
    chk("rst1_a_ready", {31'd0, a_ready}, 32'd0);
    tick();
    chk("rst2_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_we", we, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);

    // 2: A only, addr 5
    rst_n = 1'b1;
    #1;
    chk("t2_a_ready", {31'd0, a_ready}, 32'd1);
    chk("t2_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    chk("t2_we", we, 32'h00000020);
    chk("t2_wr_data", wr_data, 32'h00ABCDEF);
    chk("t2_wr_valid", {31'd0, wr_valid}, 32'd1);
    tick();
    chk("t2_we_after", we, 32'd0);
    chk("t2_wr_valid_after", {31'd0, wr_valid}, 32'd0);
    chk("t2_wr_data_hold", wr_data, 32'h00ABCDEF);

    // 3: after reset, both valid -> A then B
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd1;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'd2;
    #1;
    chk("t3_a_ready", {31'd0, a_ready}, 32'd1);
    chk("t3_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    chk("t3_we_a", we, 32'h00000008);
    chk("t3_data_a", wr_data, 32'd1);
    #1;
    chk("t3_b_ready2", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    chk("t3_we_b", we, 32'h00000010);
    chk("t3_data_b", wr_data, 32'd2);

    // 4: continuous contention, grants A,B,A,B
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA0A0A0A0;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB0B0B0B0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t4_b_ready", {31'd0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("t4_we", we, (i % 2 == 0) ? 32'h2 : 32'h4);
      chk("t4_wr_data", wr_data, (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB0B0B0B0);
    end
`ifdef WB_ARB_STATS_EN
    chk("t4_conflict_cnt", {16'd0, conflict_cnt}, 32'd4);
`endif
    a_valid = 1'b0; b_valid = 1'b0;

    // 5: B only, r0 write is accepted but discarded
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
    #1;
    chk("t5_b_ready", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    chk("t5_wr_valid", {31'd0, wr_valid}, 32'd1);
    chk("t5_we", we, 32'd0);
    chk("t5_wr_data", wr_data, 32'hFFFFFFFF);

    // 6: reset mid-stream, first grant after release goes to A
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11111111;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22222222;
    tick();
    chk("t6_we_pre", we, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("t6_a_ready_rst", {31'd0, a_ready}, 32'd0);
    chk("t6_b_ready_rst", {31'd0, b_ready}, 32'd0);
    tick();
    chk("t6_we_rst", we, 32'd0);
    chk("t6_wr_valid_rst", {31'd0, wr_valid}, 32'd0);
`ifdef WB_ARB_STATS_EN
    chk("t6_cnt_rst", {16'd0, conflict_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("t6_a_ready_rel", {31'd0, a_ready}, 32'd1);
    chk("t6_b_ready_rel", {31'd0, b_ready}, 32'd0);
    tick();
    chk("t6_we_rel", we, 32'h2);
    chk("t6_wr_data_rel", wr_data, 32'h11111111);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
